rvvi_retire_queue: RTL and testbench

RVVI_RETIRE_QUEUE -- requirements
Module: rvvi_retire_queue

---
 rtl/rvvi_retire_queue.sv | 147 ++++++++++++++
 tb/tb_rvvi_retire_queue.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/rvvi_retire_queue.sv
// RVVI retire-event queue: circular FIFO of DEPTH trace events with sticky overflow flag.
// Optional sequence checking of in_order is enabled by defining RVVI_ORDER_CHECK_EN.
module rvvi_retire_queue #(
  parameter int ILEN  = 32,
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [63:0]            in_order,
  input  logic [ILEN-1:0]        in_insn,
  input  logic [XLEN-1:0]        in_pc_rdata,
  input  logic [XLEN-1:0]        in_pc_wdata,
  input  logic                   in_trap,
  input  logic                   in_halt,
  input  logic [1:0]             in_mode,
  input  logic                   in_rd_wb,
  input  logic [4:0]             in_rd_addr,
  input  logic [XLEN-1:0]        in_rd_wdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [63:0]            out_order,
  output logic [ILEN-1:0]        out_insn,
  output logic [XLEN-1:0]        out_pc_rdata,
  output logic [XLEN-1:0]        out_pc_wdata,
  output logic                   out_trap,
  output logic                   out_halt,
  output logic [1:0]             out_mode,
  output logic                   out_rd_wb,
  output logic [4:0]             out_rd_addr,
  output logic [XLEN-1:0]        out_rd_wdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   order_err,
  output logic [63:0]            err_order
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [63:0]     order;
    logic [ILEN-1:0] insn;
    logic [XLEN-1:0] pc_rdata;
    logic [XLEN-1:0] pc_wdata;
    logic            trap;
    logic            halt;
    logic [1:0]      mode;
    logic            rd_wb;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_wdata;
  } entry_t;

  entry_t        r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_overflow;

  logic   w_full;
  logic   w_empty;
  logic   w_pop;
  logic   w_push;
  entry_t w_in;
  entry_t w_head;

  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty && out_ready;
  // A full queue still accepts when the head leaves in the same cycle.
  assign w_push  = in_valid && (!w_full || w_pop);

  assign w_in = '{order: in_order, insn: in_insn, pc_rdata: in_pc_rdata,
                  pc_wdata: in_pc_wdata, trap: in_trap, halt: in_halt,
                  mode: in_mode, rd_wb: in_rd_wb, rd_addr: in_rd_addr,
                  rd_wdata: in_rd_wdata};

  // Empty forces zeros, so async reset of the count also clears out_* at once.
  assign w_head = w_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (in_valid && !w_push) r_overflow <= 1'b1;
    end
  end

  assign out_valid    = !w_empty;
  assign out_order    = w_head.order;
  assign out_insn     = w_head.insn;
  assign out_pc_rdata = w_head.pc_rdata;
  assign out_pc_wdata = w_head.pc_wdata;
  assign out_trap     = w_head.trap;
  assign out_halt     = w_head.halt;
  assign out_mode     = w_head.mode;
  assign out_rd_wb    = w_head.rd_wb;
  assign out_rd_addr  = w_head.rd_addr;
  assign out_rd_wdata = w_head.rd_wdata;
  assign count        = r_count;
  assign overflow     = r_overflow;

`ifdef RVVI_ORDER_CHECK_EN
  logic        r_seen;
  logic [63:0] r_expected;
  logic        r_order_err;
  logic [63:0] r_err_order;

  // Every observed event, dropped or not, advances the expected order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seen      <= 1'b0;
      r_expected  <= '0;
      r_order_err <= 1'b0;
      r_err_order <= '0;
    end else if (in_valid) begin
      r_seen     <= 1'b1;
      r_expected <= in_order + 64'd1;
      if (r_seen && (in_order != r_expected) && !r_order_err) begin
        r_order_err <= 1'b1;
        r_err_order <= r_expected;
      end
    end
  end

  assign order_err = r_order_err;
  assign err_order = r_err_order;
`else
  assign order_err = 1'b0;
  assign err_order = '0;
`endif

endmodule

// File: tb/tb_rvvi_retire_queue.sv
// Directed bench for rvvi_retire_queue (DEPTH=8); order checks follow RVVI_ORDER_CHECK_EN.
module tb_rvvi_retire_queue;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [63:0] in_order;
  logic [31:0] in_insn;
  logic [31:0] in_pc_rdata;
  logic [31:0] in_pc_wdata;
  logic        in_trap;
  logic        in_halt;
  logic [1:0]  in_mode;
  logic        in_rd_wb;
  logic [4:0]  in_rd_addr;
  logic [31:0] in_rd_wdata;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_order;
  logic [31:0] out_insn;
  logic [31:0] out_pc_rdata;
  logic [31:0] out_pc_wdata;
  logic        out_trap;
  logic        out_halt;
  logic [1:0]  out_mode;
  logic        out_rd_wb;
  logic [4:0]  out_rd_addr;
  logic [31:0] out_rd_wdata;
  logic [3:0]  count;
  logic        overflow;
  logic        order_err;
  logic [63:0] err_order;

  int errors = 0;
  int checks = 0;

  rvvi_retire_queue #(.ILEN(32), .XLEN(32), .DEPTH(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_order(in_order),
    .in_insn(in_insn), .in_pc_rdata(in_pc_rdata), .in_pc_wdata(in_pc_wdata),
    .in_trap(in_trap), .in_halt(in_halt), .in_mode(in_mode),
    .in_rd_wb(in_rd_wb), .in_rd_addr(in_rd_addr), .in_rd_wdata(in_rd_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_order(out_order),
    .out_insn(out_insn), .out_pc_rdata(out_pc_rdata), .out_pc_wdata(out_pc_wdata),
    .out_trap(out_trap), .out_halt(out_halt), .out_mode(out_mode),
    .out_rd_wb(out_rd_wb), .out_rd_addr(out_rd_addr), .out_rd_wdata(out_rd_wdata),
    .count(count), .overflow(overflow), .order_err(order_err), .err_order(err_order)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_insn(input logic [63:0] ord);
    return 32'h0000_0013 + ord[31:0];
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [63:0] ord);
    return ~ord[31:0];
  endfunction

  task automatic set_ev(input logic [63:0] ord);
    in_order    = ord;
    in_insn     = exp_insn(ord);
    in_pc_rdata = 32'h8000_1000 + {ord[29:0], 2'b00};
    in_pc_wdata = 32'h8000_1004 + {ord[29:0], 2'b00};
    in_trap     = ord[0];
    in_halt     = 1'b0;
    in_mode     = 2'b11;
    in_rd_wb    = 1'b1;
    in_rd_addr  = ord[4:0];
    in_rd_wdata = exp_wdata(ord);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    set_ev(64'd0);
    #3;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_order", out_order, 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_order_err", 64'(order_err), 64'd0);
    chk("rst_err_order", err_order, 64'd0);
    step();
    reset = 1'b0;

    // Single event passes through with one cycle latency.
    set_ev(64'd1);
    in_pc_rdata = 32'h8000_0000;
    in_valid    = 1'b1;
    out_ready   = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t1_out_valid", 64'(out_valid), 64'd1);
    chk("t1_out_order", out_order, 64'd1);
    chk("t1_out_pc", 64'(out_pc_rdata), 64'h8000_0000);
    chk("t1_count", 64'(count), 64'd1);
    step();
    chk("t1_count_after_pop", 64'(count), 64'd0);
    chk("t1_out_valid_empty", 64'(out_valid), 64'd0);
    chk("t1_out_order_empty", out_order, 64'd0);

    // Fill with ready low; head payload must hold while more events arrive.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_ev(64'(10 + i));
      in_valid = 1'b1;
      step();
      chk("fill_count", 64'(count), 64'(i + 1));
      chk("hold_order", out_order, 64'd10);
      chk("hold_insn", 64'(out_insn), 64'(exp_insn(64'd10)));
    end
    chk("full_overflow", 64'(overflow), 64'd0);

    // Push and pop together on a full queue.
    set_ev(64'd18);
    out_ready = 1'b1;
    step();
    chk("pp_count", 64'(count), 64'd8);
    chk("pp_overflow", 64'(overflow), 64'd0);
    chk("pp_head", out_order, 64'd11);

    // Push with no pop on a full queue is dropped.
    set_ev(64'd19);
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    chk("drop_count", 64'(count), 64'd8);
    chk("drop_overflow", 64'(overflow), 64'd1);
    chk("drop_head", out_order, 64'd11);

    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_valid", 64'(out_valid), 64'd1);
      chk("drain_order", out_order, 64'(11 + i));
      chk("drain_wdata", 64'(out_rd_wdata), 64'(exp_wdata(64'(11 + i))));
      step();
    end
    chk("drain_count", 64'(count), 64'd0);
    chk("drain_valid_end", 64'(out_valid), 64'd0);
    chk("overflow_sticky", 64'(overflow), 64'd1);

    // Asynchronous reset mid-cycle with five entries queued.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_ev(64'(20 + i));
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    chk("pre_rst_count", 64'(count), 64'd5);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("async_rst_count", 64'(count), 64'd0);
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_order", out_order, 64'd0);
    chk("async_rst_overflow", 64'(overflow), 64'd0);
    #1;
    reset = 1'b0;
    set_ev(64'd100);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("post_rst_count", 64'(count), 64'd1);
    chk("post_rst_order", out_order, 64'd100);
    chk("post_rst_order_err", 64'(order_err), 64'd0);

    // Order sequence 5,6,8,9 with a fresh reset.
    reset = 1'b1;
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    set_ev(64'd5);
    in_valid = 1'b1;
    step();
    chk("seq5_err", 64'(order_err), 64'd0);
    set_ev(64'd6);
    step();
    chk("seq6_err", 64'(order_err), 64'd0);
    set_ev(64'd8);
    step();
`ifdef RVVI_ORDER_CHECK_EN
    chk("seq8_err", 64'(order_err), 64'd1);
    chk("seq8_err_order", err_order, 64'd7);
`else
    chk("seq8_err_off", 64'(order_err), 64'd0);
    chk("seq8_err_order_off", err_order, 64'd0);
`endif
    set_ev(64'd9);
    step();
    in_valid = 1'b0;
`ifdef RVVI_ORDER_CHECK_EN
    chk("seq9_err", 64'(order_err), 64'd1);
    chk("seq9_err_order", err_order, 64'd7);
`else
    chk("seq9_err_off", 64'(order_err), 64'd0);
    chk("seq9_err_order_off", err_order, 64'd0);
`endif
    chk("seq_head", out_order, 64'd9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
